// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared types, defaults and wrap helper for the battleship board
package battleship_pkg;

    localparam int GRID_DEFAULT       = 5;
    localparam int SHIP_COUNT_DEFAULT = 3;

    typedef enum logic [2:0] {
        CELL_EMPTY  = 3'd0,
        CELL_SHIP   = 3'd1,
        CELL_HIT    = 3'd2,
        CELL_MISS   = 3'd3,
        CELL_CURSOR = 3'd6
    } cell_code_t;

    typedef enum logic [1:0] {
        PH_PLACE  = 2'd0,
        PH_BATTLE = 2'd1,
        PH_DONE   = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        RESP_MISS         = 2'd0,
        RESP_HIT          = 2'd1,
        RESP_REPEAT       = 2'd2,
        RESP_OUT_OF_RANGE = 2'd3
    } resp_code_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // One step of a 0..grid-1 coordinate with wrap-around at both edges.
    function automatic logic [2:0] wrap_step(input logic [2:0] v, input logic inc, input int grid);
        logic [2:0] top;
        top = 3'(grid - 1);
        if (inc) begin
            return (v == top) ? 3'd0 : v + 3'd1;
        end
        return (v == 3'd0) ? top : v - 3'd1;
    endfunction

endpackage

// File: rtl/board_cursor.sv
// rtl/board_cursor.sv - wrap-around cursor x/y counters driven by move pulses
module board_cursor
    import battleship_pkg::*;
#(
    parameter int GRID = GRID_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       move_valid,
    input  logic [1:0] move_dir,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y
);

    logic [2:0] x_q, x_d;
    logic [2:0] y_q, y_d;
    dir_t       dir;

    // Next cursor position: clear wins, otherwise one wrapped step in the pulsed direction.
    always_comb begin
        dir = dir_t'(move_dir);
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = 3'd0;
            y_d = 3'd0;
        end else if (move_valid) begin
            case (dir)
                DIR_UP:    y_d = wrap_step(y_q, 1'b0, GRID);
                DIR_DOWN:  y_d = wrap_step(y_q, 1'b1, GRID);
                DIR_LEFT:  x_d = wrap_step(x_q, 1'b0, GRID);
                default:   x_d = wrap_step(x_q, 1'b1, GRID);
            endcase
        end
    end

    // Cursor registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= 3'd0;
            y_q <= 3'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign cursor_x = x_q;
    assign cursor_y = y_q;

endmodule

// File: rtl/board_matrix_writer.sv
// rtl/board_matrix_writer.sv - battleship board storage, phase FSM, shot handling; CURSOR_OVERLAY_EN highlights the cursor cell
module board_matrix_writer
    import battleship_pkg::*;
#(
    parameter int GRID       = GRID_DEFAULT,
    parameter int SHIP_COUNT = SHIP_COUNT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_valid,
    input  logic [1:0] move_dir,
    input  logic       place_valid,
    input  logic       new_game,
    input  logic       shot_valid,
    input  logic [2:0] shot_x,
    input  logic [2:0] shot_y,
    output logic       shot_ready,
    output logic       resp_valid,
    output logic [1:0] resp_code,
    output logic       place_err,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic [1:0] phase,
    output logic       game_over,
    output int         matrix [GRID-1:0][GRID-1:0]
);

    localparam int CW = $clog2(GRID * GRID + 1);

    cell_code_t     cell_q [GRID-1:0][GRID-1:0];
    cell_code_t     cell_d [GRID-1:0][GRID-1:0];
    int             matrix_q [GRID-1:0][GRID-1:0];
    phase_t         phase_q;
    logic [CW-1:0]  ships_q;
    logic [CW-1:0]  hits_q;
    logic           resp_valid_q;
    resp_code_t     resp_code_q;
    logic           place_err_q;

    logic           place_ok;
    logic           place_bad;
    logic           shot_acc;
    logic           shot_in_range;
    logic           shot_hit;
    resp_code_t     shot_code;
    cell_code_t     cur_cell;
    cell_code_t     shot_cell;

    board_cursor #(.GRID(GRID)) u_cursor (
        .clk        (clk),
        .rst        (rst),
        .clear      (new_game),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y)
    );

    // resp_valid_q doubles as the pending flag that blocks the next shot for one cycle.
    assign shot_ready = (phase_q == PH_BATTLE) && !resp_valid_q;

    // Resolve place/shot events and the next board contents; new_game clears everything.
    always_comb begin
        cell_d        = cell_q;
        cur_cell      = cell_q[cursor_x][cursor_y];
        shot_in_range = (int'(shot_x) < GRID) && (int'(shot_y) < GRID);
        shot_cell     = shot_in_range ? cell_q[shot_x][shot_y] : CELL_EMPTY;
        place_ok      = place_valid && !new_game && (phase_q == PH_PLACE) && (cur_cell == CELL_EMPTY);
        place_bad     = place_valid && !new_game && !place_ok;
        shot_acc      = shot_valid && shot_ready && !new_game;
        shot_hit      = 1'b0;
        shot_code     = RESP_OUT_OF_RANGE;
        if (shot_in_range) begin
            case (shot_cell)
                CELL_SHIP: begin
                    shot_code = RESP_HIT;
                    shot_hit  = 1'b1;
                end
                CELL_EMPTY: shot_code = RESP_MISS;
                default:    shot_code = RESP_REPEAT;
            endcase
        end
        if (place_ok) begin
            cell_d[cursor_x][cursor_y] = CELL_SHIP;
        end
        if (shot_acc && shot_in_range) begin
            if (shot_hit) begin
                cell_d[shot_x][shot_y] = CELL_HIT;
            end else if (shot_cell == CELL_EMPTY) begin
                cell_d[shot_x][shot_y] = CELL_MISS;
            end
        end
        if (new_game) begin
            for (int i = 0; i < GRID; i++) begin
                for (int j = 0; j < GRID; j++) begin
                    cell_d[i][j] = CELL_EMPTY;
                end
            end
        end
    end

    // Board, drawer matrix, phase FSM, counters and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GRID; i++) begin
                for (int j = 0; j < GRID; j++) begin
                    cell_q[i][j]   <= CELL_EMPTY;
                    matrix_q[i][j] <= 0;
                end
            end
            phase_q      <= PH_PLACE;
            ships_q      <= '0;
            hits_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= RESP_MISS;
            place_err_q  <= 1'b0;
        end else begin
            cell_q       <= cell_d;
            resp_valid_q <= shot_acc;
            place_err_q  <= place_bad;
            if (shot_acc) begin
                resp_code_q <= shot_code;
            end
            for (int i = 0; i < GRID; i++) begin
                for (int j = 0; j < GRID; j++) begin
`ifdef CURSOR_OVERLAY_EN
                    // Overlay uses the registered cursor, so it trails cursor moves by a cycle.
                    matrix_q[i][j] <= (3'(i) == cursor_x && 3'(j) == cursor_y)
                                      ? int'(CELL_CURSOR) : int'(cell_d[i][j]);
`else
                    matrix_q[i][j] <= int'(cell_d[i][j]);
`endif
                end
            end
            if (new_game) begin
                phase_q <= PH_PLACE;
                ships_q <= '0;
                hits_q  <= '0;
            end else begin
                case (phase_q)
                    PH_PLACE: begin
                        if (place_ok) begin
                            ships_q <= ships_q + CW'(1);
                            if (ships_q == CW'(SHIP_COUNT - 1)) begin
                                phase_q <= PH_BATTLE;
                            end
                        end
                    end
                    PH_BATTLE: begin
                        if (shot_acc && shot_hit) begin
                            hits_q <= hits_q + CW'(1);
                            if (hits_q == CW'(SHIP_COUNT - 1)) begin
                                phase_q <= PH_DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign resp_valid = resp_valid_q && !new_game;
    assign resp_code  = resp_code_q;
    assign place_err  = place_err_q;
    assign phase      = phase_q;
    assign game_over  = (phase_q == PH_DONE);
    assign matrix     = matrix_q;

endmodule
